// File: rtl/mcb_emu_pkg.sv
// Shared definitions for the MCB port emulator.
//   - MCB_INSTR_* : p0_cmd_instr encodings understood by the engine
//   - engine_state_t : engine FSM encoding, also visible on the engine_state debug port
//   - ERR_* : bit positions inside err_flags
//   - mcb_cmd_t / mcb_wr_t : packed entries of the command and write-data FIFOs
package mcb_emu_pkg;

   localparam logic [2:0] MCB_INSTR_WR    = 3'b000;
   localparam logic [2:0] MCB_INSTR_RD    = 3'b001;
   localparam logic [2:0] MCB_INSTR_WR_AP = 3'b010;
   localparam logic [2:0] MCB_INSTR_RD_AP = 3'b011;

   typedef enum logic [2:0] {
      ENG_IDLE     = 3'd0,
      ENG_DECODE   = 3'd1,
      ENG_WRITE    = 3'd2,
      ENG_RD_WAIT  = 3'd3,
      ENG_READ     = 3'd4,
      ENG_RD_DRAIN = 3'd5
   } engine_state_t;

   localparam int ERR_CMD_OVERFLOW = 2;
   localparam int ERR_WR_OVERFLOW  = 1;
   localparam int ERR_RD_UNDERFLOW = 0;

   typedef struct packed {
      logic [2:0]  instr;
      logic [29:0] byte_addr;
      logic [5:0]  bl;
   } mcb_cmd_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] data;
   } mcb_wr_t;

   // Auto-precharge makes no difference to a block RAM, so both flavours map together.
   function automatic logic is_write(input logic [2:0] instr);
      return (instr == MCB_INSTR_WR) || (instr == MCB_INSTR_WR_AP);
   endfunction

   function automatic logic is_read(input logic [2:0] instr);
      return (instr == MCB_INSTR_RD) || (instr == MCB_INSTR_RD_AP);
   endfunction

endpackage

// File: rtl/mcb_emu_fifo.sv
// Synchronous FIFO used for the command, write-data and read-data queues.
// dout always shows the head entry (combinational view); callers that need a
// registered read port register it themselves.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (empties the FIFO)
//   push, din      : write request / data; dropped when full
//   pop            : remove head entry; ignored when empty
//   dout           : current head entry
//   full, empty    : occupancy flags
//   count          : occupancy, 0..DEPTH
module mcb_emu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mcb_port_emulator.sv
// Responder for the Spartan-6 MCB user port p0: command, write-data and
// read-data FIFOs in front of a byte-lane block RAM, so the SDRAM initiator
// can run without a DDR2 controller.
// Optional feature macro: MCB_EMU_ERR_CHECK_EN (sticky overflow/underflow flags;
// when undefined err_flags is tied to zero).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   calib_done        : high CALIB_CYCLES clocks after reset release
//   p0_cmd_*          : command push {instr, byte_addr, bl}, p0_cmd_full
//   p0_wr_*           : write-data push {data, mask}, full flag, occupancy
//   p0_rd_*           : read-data pop (data valid the cycle after p0_rd_en), empty, occupancy
//   err_flags         : sticky {cmd_overflow, wr_overflow, rd_underflow}
//   engine_state      : engine FSM state, debug visibility
// Handshake: every push/pop is a single-cycle strobe; a push is taken only when
// the matching full flag is low, a pop only when the matching empty flag is low,
// otherwise the strobe is dropped and occupancy is unchanged.
module mcb_port_emulator
   import mcb_emu_pkg::*;
#(
   parameter int  MEM_AW       = 10,
   parameter int  CMD_DEPTH    = 4,
   parameter int  DATA_DEPTH   = 64,
   parameter int  CALIB_CYCLES = 16,
   localparam int CW           = $clog2(DATA_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   output logic          calib_done,
   input  logic          p0_cmd_en,
   input  logic [2:0]    p0_cmd_instr,
   input  logic [29:0]   p0_cmd_byte_addr,
   input  logic [5:0]    p0_cmd_bl,
   output logic          p0_cmd_full,
   input  logic          p0_wr_en,
   input  logic [31:0]   p0_wr_data,
   input  logic [3:0]    p0_wr_mask,
   output logic          p0_wr_full,
   output logic [CW-1:0] p0_wr_count,
   input  logic          p0_rd_en,
   output logic [31:0]   p0_rd_data,
   output logic          p0_rd_empty,
   output logic [CW-1:0] p0_rd_count,
   output logic [2:0]    err_flags,
   output engine_state_t engine_state
);

   localparam int CALW = $clog2(CALIB_CYCLES + 1);

   // ---------------- calibration delay ----------------
   logic [CALW-1:0] cal_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cal_cnt    <= '0;
         calib_done <= 1'b0;
      end else if (!calib_done) begin
         cal_cnt    <= cal_cnt + 1'b1;
         calib_done <= (cal_cnt == CALW'(CALIB_CYCLES - 1));
      end
   end

   // ---------------- FIFOs ----------------
   mcb_cmd_t                   cmd_in, cmd_head;
   mcb_wr_t                    wr_in, wr_head;
   logic                       cmd_empty, cmd_pop;
   logic                       wr_empty, wr_pop;
   logic [31:0]                rd_head, ram_q;
   logic                       rd_vld;
   logic                       rd_full_unused;
   logic [$clog2(CMD_DEPTH):0] cmd_count_unused;

   assign cmd_in = {p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl};
   assign wr_in  = {p0_wr_mask, p0_wr_data};

   mcb_emu_fifo #(.WIDTH($bits(mcb_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk(clk), .reset(reset), .push(p0_cmd_en), .pop(cmd_pop), .din(cmd_in),
      .dout(cmd_head), .full(p0_cmd_full), .empty(cmd_empty), .count(cmd_count_unused)
   );

   mcb_emu_fifo #(.WIDTH($bits(mcb_wr_t)), .DEPTH(DATA_DEPTH)) u_wr_fifo (
      .clk(clk), .reset(reset), .push(p0_wr_en), .pop(wr_pop), .din(wr_in),
      .dout(wr_head), .full(p0_wr_full), .empty(wr_empty), .count(p0_wr_count)
   );

   mcb_emu_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_rd_fifo (
      .clk(clk), .reset(reset), .push(rd_vld), .pop(p0_rd_en), .din(ram_q),
      .dout(rd_head), .full(rd_full_unused), .empty(p0_rd_empty), .count(p0_rd_count)
   );

   // Standard (non-FWFT) read port: the head word is registered on a valid pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          p0_rd_data <= '0;
      else if (p0_rd_en && !p0_rd_empty) p0_rd_data <= rd_head;
   end

   // ---------------- engine ----------------
   engine_state_t     state, state_nx;
   logic [MEM_AW-1:0] addr;
   logic [6:0]        word_cnt;
   logic [5:0]        bl_q;
   logic [CW-1:0]     rd_space;
   logic              burst_fits;
   logic              addr_unused;

   // Address bits outside the word index are intentionally ignored.
   assign addr_unused = ^{cmd_head.byte_addr[29:MEM_AW+2], cmd_head.byte_addr[1:0]};

   // Reads only start once the whole burst fits, so the read FIFO never overflows.
   assign rd_space   = CW'(DATA_DEPTH) - p0_rd_count;
   assign burst_fits = (int'(rd_space) >= int'(bl_q) + 1);
   assign engine_state = state;

   always_comb begin
      state_nx = state;
      cmd_pop  = 1'b0;
      wr_pop   = 1'b0;
      case (state)
         ENG_IDLE:     if (!cmd_empty && calib_done) state_nx = ENG_DECODE;
         ENG_DECODE: begin
            cmd_pop = 1'b1;
            if (is_write(cmd_head.instr))     state_nx = ENG_WRITE;
            else if (is_read(cmd_head.instr)) state_nx = ENG_RD_WAIT;
            else                              state_nx = ENG_IDLE;
         end
         ENG_WRITE: begin
            if (!wr_empty) begin
               wr_pop = 1'b1;
               if (word_cnt == 7'd1) state_nx = ENG_IDLE;
            end
         end
         ENG_RD_WAIT:  if (burst_fits) state_nx = ENG_READ;
         ENG_READ:     if (word_cnt == 7'd1) state_nx = ENG_RD_DRAIN;
         ENG_RD_DRAIN: state_nx = ENG_IDLE;
         default:      state_nx = ENG_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ENG_IDLE;
         addr     <= '0;
         word_cnt <= '0;
         bl_q     <= '0;
         rd_vld   <= 1'b0;
      end else begin
         state  <= state_nx;
         // RAM read data lands one cycle after the READ-state address.
         rd_vld <= (state == ENG_READ);
         if (state == ENG_DECODE) begin
            addr     <= cmd_head.byte_addr[MEM_AW+1:2];
            bl_q     <= cmd_head.bl;
            word_cnt <= {1'b0, cmd_head.bl} + 7'd1;
         end else if (wr_pop || state == ENG_READ) begin
            addr     <= addr + 1'b1;  // wraps at the top of memory
            word_cnt <= word_cnt - 7'd1;
         end
      end
   end

   // ---------------- memory ----------------
   logic [31:0] ram [2**MEM_AW];

   always_ff @(posedge clk) begin
      if (wr_pop) begin
         for (int i = 0; i < 4; i++) begin
            if (!wr_head.mask[i]) ram[addr][8*i +: 8] <= wr_head.data[8*i +: 8];
         end
      end
      ram_q <= ram[addr];
   end

   // ---------------- error flags ----------------
`ifdef MCB_EMU_ERR_CHECK_EN
   logic [2:0] err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         if (p0_cmd_en && p0_cmd_full) err_q[ERR_CMD_OVERFLOW] <= 1'b1;
         if (p0_wr_en && p0_wr_full)   err_q[ERR_WR_OVERFLOW]  <= 1'b1;
         if (p0_rd_en && p0_rd_empty)  err_q[ERR_RD_UNDERFLOW] <= 1'b1;
      end
   end

   assign err_flags = err_q;
`else
   assign err_flags = 3'b000;
`endif

endmodule
